seg_disp_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver with decimal point. It is the next generation of the board display block that sits beside the SOPC and shows processor or debug values on the LED digits. It generalises digit count, refresh rate and output polarity, and adds per-digit blanking and decimal points. Loads are double-buffered and swap only at frame boundaries, so the display never tears mid-frame.

---
 rtl/seg_disp_pkg.sv | 24 ++
 rtl/seg_hex_decode.sv | 20 ++
 rtl/seg_disp_mux.sv | 139 +++++++++++++
 tb/tb_seg_disp_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// hex glyph table, segment bit positions and counter-width helper.
package seg_disp_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high a..g, bit 0 = a; A b C d E F for the upper six codes.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to logical (active-high) segment decode with
// decimal point and blanking; blank darkens all eight segments.
module seg_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            seg[SEG_G:SEG_A] = HEX_SEG[nibble];
            seg[SEG_DP]      = dp;
        end
    end

endmodule

// File: rtl/seg_disp_mux.sv
// Time-multiplexed seven-segment driver with double-buffered frame-aligned loads.
// Optional leading-zero suppression: define SEG_DISP_LEADZERO_BLANK_EN.
module seg_disp_mux
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    output logic [7:0]                led,
    output logic [NUM_DIGITS-1:0]     sele,
    output logic                      frame_done
);

    localparam int unsigned PW = cnt_w(CLK_DIV);
    localparam int unsigned IW = cnt_w(NUM_DIGITS);
    localparam logic [7:0]            LED_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   pend_data, act_data;
    logic [NUM_DIGITS-1:0]     pend_dp, act_dp, pend_blank, act_blank;
    logic                      pend_valid;

    logic                      tick, wrap;
    logic [IW-1:0]             nxt_idx;
    logic [4*NUM_DIGITS-1:0]   nxt_data;
    logic [NUM_DIGITS-1:0]     nxt_dp, nxt_blank;
    logic [NUM_DIGITS-1:0]     lz_mask, sel_onehot;
    logic [3:0]                cur_nib;
    logic                      cur_dp, cur_blank;
    logic [7:0]                cur_seg;

    assign tick = (cnt == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Outputs are registered from the post-edge index and active buffer, so the
    // wrap edge already shows digit 0 with whatever the swap/bypass brings in.
    always_comb begin
        nxt_idx = idx;
        if (wrap)
            nxt_idx = '0;
        else if (tick)
            nxt_idx = idx + IW'(1);

        nxt_data  = act_data;
        nxt_dp    = act_dp;
        nxt_blank = act_blank;
        if (wrap && load) begin
            nxt_data  = data_i;
            nxt_dp    = dp_i;
            nxt_blank = blank_i;
        end else if (wrap && pend_valid) begin
            nxt_data  = pend_data;
            nxt_dp    = pend_dp;
            nxt_blank = pend_blank;
        end
    end

`ifdef SEG_DISP_LEADZERO_BLANK_EN
    // Scan from the most significant digit down while nibbles stay zero.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
            run = run & (nxt_data[4*(NUM_DIGITS-j) +: 4] == 4'h0);
            lz_mask[NUM_DIGITS-j] = run & ~nxt_dp[NUM_DIGITS-j];
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_onehot = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (nxt_idx == IW'(k)) begin
                cur_nib       = nxt_data[4*k +: 4];
                cur_dp        = nxt_dp[k];
                cur_blank     = nxt_blank[k] | lz_mask[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            led        <= LED_OFF;
            sele       <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + PW'(1);
            idx        <= nxt_idx;
            act_data   <= nxt_data;
            act_dp     <= nxt_dp;
            act_blank  <= nxt_blank;
            if (wrap) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_data  <= data_i;
                pend_dp    <= dp_i;
                pend_blank <= blank_i;
                pend_valid <= 1'b1;
            end
            led        <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
            sele       <= SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_disp_mux.sv
// Scoreboard bench for seg_disp_mux (4 digits, 4 clocks per slot, active-low).
// Expected slot contents are queued as loads are driven and popped per slot.
module tb_seg_disp_mux;

    localparam int ND = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic [7:0]  led;
    logic [3:0]  sele;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb_q [$];
    logic [11:0] mon_e;
    logic [3:0]  prev_sele;
    bit          mon_en = 1'b0;
    bit          fd_seen = 1'b0;
    int          cyc = 0;
    int          last_fd = 0;

    seg_disp_mux #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_i     (data_i),
        .dp_i       (dp_i),
        .blank_i    (blank_i),
        .led        (led),
        .sele       (sele),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] exp_led(input logic [15:0] data, input logic [3:0] dp,
                                           input logic [3:0] blank, input int d);
        logic [3:0] nib;
        logic       dark;
        nib  = data[4*d +: 4];
        dark = blank[d];
`ifdef SEG_DISP_LEADZERO_BLANK_EN
        if (d > 0 && (data >> (4*d)) == 16'h0 && !dp[d])
            dark = 1'b1;
`endif
        if (dark)
            return 8'hFF;
        return ~{dp[d], glyph(nib)};
    endfunction

    task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank);
        logic [3:0] s;
        for (int d = 0; d < ND; d++) begin
            s = ~(4'b0001 << d);
            sb_q.push_back({s, exp_led(data, dp, blank, d)});
        end
    endtask

    task automatic wait_slot_start(input int d);
        logic [3:0] prev, tgt;
        tgt  = ~(4'b0001 << d);
        prev = sele;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sele !== prev && sele === tgt)
                return;
            prev = sele;
        end
        check("wait_slot_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_i  = d;
        dp_i    = p;
        blank_i = b;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0)
                return;
        end
        check("sb_drain", sb_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_sele = sele;
            fd_seen   = 1'b0;
        end else begin
            if (mon_en && sele !== prev_sele) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("slot_sele", sele, mon_e[11:8]);
                    check("slot_led", led, mon_e[7:0]);
                end
            end
            prev_sele = sele;
            if (frame_done) begin
                check("fd_sele", sele, 4'b1110);
                if (fd_seen)
                    check("fd_gap", cyc - last_fd, ND * CD);
                fd_seen = 1'b1;
                last_fd = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_led", led, 8'hFF);
        check("rst_sele", sele, 4'hF);
        check("rst_fd", frame_done, 1'b0);

        push_frame(16'h0000, 4'h0, 4'h0);
        mon_en = 1'b1;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        check("first_sele", sele, 4'b1110);
        check("first_led", led, 8'hC0);

        // mid-frame load at digit 2: digits 2/3 of this frame keep old data
        wait_slot_start(2);
        @(negedge clk);
        do_load(16'h12AF, 4'h0, 4'h0);
        push_frame(16'h12AF, 4'h0, 4'h0);

        // load exactly on the wrap edge bypasses into the active buffer
        wait_slot_start(0);
        wait_slot_start(3);
        repeat (3) @(negedge clk);
        push_frame(16'h0005, 4'h0, 4'h0);
        do_load(16'h0005, 4'h0, 4'h0);

        // two loads in one frame: last one wins
        wait_slot_start(1);
        @(negedge clk);
        do_load(16'h1111, 4'h0, 4'h0);
        wait_slot_start(2);
        @(negedge clk);
        do_load(16'h2222, 4'h0, 4'h0);
        push_frame(16'h2222, 4'h0, 4'h0);

        // decimal point and blanking
        wait_slot_start(0);
        @(negedge clk);
        do_load(16'h8888, 4'b0100, 4'b1000);
        push_frame(16'h8888, 4'b0100, 4'b1000);

        // leading zeros (suppressed only when the macro is defined)
        wait_slot_start(0);
        wait_slot_start(1);
        do_load(16'h0070, 4'h0, 4'h0);
        push_frame(16'h0070, 4'h0, 4'h0);

        // reset mid-frame with a pending load: pending must be discarded
        wait_slot_start(0);
        wait_slot_start(1);
        do_load(16'h3333, 4'h0, 4'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_led", led, 8'hFF);
        check("midrst_sele", sele, 4'hF);
        check("midrst_fd", frame_done, 1'b0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        push_frame(16'h0000, 4'h0, 4'h0);
        push_frame(16'h0000, 4'h0, 4'h0);
        rst = 1'b0;
        wait_empty();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
